ddr_crc_arbiter: RTL and testbench

//  Parametrised CRC5 engine shared by N_CH HDR-DDR requesters (TX, RX, CCC).

---
 rtl/ddr_crc_arbiter_pkg.sv | 22 ++
 rtl/ddr_crc_arbiter_rr.sv | 24 ++
 rtl/ddr_crc_arbiter.sv | 96 +++++++++
 tb/tb_ddr_crc_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_crc_arbiter_pkg.sv
// ddr_crc_arbiter_pkg: shared CRC constants, arbiter FSM states and the serial CRC step function
package ddr_crc_arbiter_pkg;
  localparam logic [4:0] CRC5_POLY = 5'h05;
  localparam logic [4:0] CRC5_SEED = 5'h1F;
  typedef enum logic [1:0] {ARB_IDLE, ARB_LOCK, ARB_DONE} arb_state_t;
  // MSB-first LFSR over the low data_w bits; crc_w <= 32 and data_w <= 64
  function automatic logic [31:0] crc5_next(input logic [31:0] crc, input logic [63:0] data,
                                            input int crc_w, input int data_w, input logic [31:0] poly);
    logic [31:0] c;
    logic [31:0] mask;
    logic fb;
    c = crc;
    mask = (32'd1 << crc_w) - 32'd1;
    for (int i = 63; i >= 0; i--) begin
      if (i < data_w) begin
        fb = c[crc_w-1] ^ data[i];
        c = ((c << 1) ^ (fb ? poly : 32'd0)) & mask;
      end
    end
    return c;
  endfunction
endpackage

// File: rtl/ddr_crc_arbiter_rr.sv
// ddr_crc_arbiter_rr: combinational rotating-priority arbiter, first requester at or after ptr wins
module ddr_crc_arbiter_rr #(
  parameter int N_CH = 2,
  parameter int IW = 1
) (
  input  logic [N_CH-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [N_CH-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!any && req[(int'(ptr) + i) % N_CH]) begin
        any = 1'b1;
        grant[(int'(ptr) + i) % N_CH] = 1'b1;
        idx = IW'((int'(ptr) + i) % N_CH);
      end
    end
  end
endmodule

// File: rtl/ddr_crc_arbiter.sv
// ddr_crc_arbiter: CRC engine shared by N_CH HDR-DDR requesters with round-robin per-frame grant lock
module ddr_crc_arbiter
  import ddr_crc_arbiter_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int DATA_W = 8,
  parameter int CRC_W = 5,
  parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(CRC5_POLY),
  parameter logic [CRC_W-1:0] CRC_SEED = CRC_W'(CRC5_SEED)
) (
  input  logic                     i_sys_clk,
  input  logic                     i_sys_rst,
  input  logic [N_CH-1:0]          i_ch_en,
  input  logic [N_CH-1:0]          i_ch_data_valid,
  input  logic [N_CH-1:0]          i_ch_last_byte,
  input  logic [N_CH*DATA_W-1:0]   i_ch_data,
  input  logic                     i_ddrccc_abort,
  output logic [N_CH-1:0]          o_ch_grant,
  output logic                     o_crc_busy,
  output logic [CRC_W-1:0]         o_txrx_crc_value,
  output logic                     o_txrx_crc_valid,
  output logic [N_CH-1:0]          o_ch_err
);
  localparam int IW = N_CH > 1 ? $clog2(N_CH) : 1;
  arb_state_t state, state_d;
  logic [N_CH-1:0] grant, grant_d, win_grant, err, err_d;
  logic [IW-1:0] ptr, ptr_d, owner, owner_d, win_idx;
  logic [CRC_W-1:0] crc, crc_d;
  logic [DATA_W-1:0] own_data;
  logic win_any;

  ddr_crc_arbiter_rr #(.N_CH(N_CH), .IW(IW)) u_rr (
    .req(i_ch_en), .ptr(ptr), .grant(win_grant), .idx(win_idx), .any(win_any)
  );

  assign own_data = i_ch_data[owner*DATA_W +: DATA_W];

  always_comb begin
    state_d = state;
    grant_d = grant;
    owner_d = owner;
    ptr_d = ptr;
    crc_d = crc;
    // only the locked owner may stream; every other valid beat is flagged and dropped
    err_d = (N_CH == 1) ? '0 : i_ch_data_valid & ~((state == ARB_LOCK) ? grant : '0);
    if (i_ddrccc_abort) begin
      state_d = ARB_IDLE;
      grant_d = '0;
      crc_d = CRC_SEED;
    end else if (state == ARB_IDLE) begin
      if (win_any) begin
        state_d = ARB_LOCK;
        grant_d = win_grant;
        owner_d = win_idx;
        ptr_d = (win_idx == IW'(N_CH - 1)) ? '0 : win_idx + 1'b1;
      end
    end else if (state == ARB_LOCK) begin
      if (!i_ch_en[owner]) begin
        state_d = ARB_IDLE;
        grant_d = '0;
        crc_d = CRC_SEED;
      end else if (i_ch_data_valid[owner]) begin
        crc_d = CRC_W'(crc5_next(32'(crc), 64'(own_data), CRC_W, DATA_W, 32'(CRC_POLY)));
        state_d = i_ch_last_byte[owner] ? ARB_DONE : ARB_LOCK;
        grant_d = i_ch_last_byte[owner] ? '0 : grant;
      end
    end else begin
      state_d = ARB_IDLE;
      crc_d = CRC_SEED;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst) begin
      state <= ARB_IDLE;
      grant <= '0;
      ptr <= '0;
      owner <= '0;
      crc <= CRC_SEED;
      err <= '0;
    end else begin
      state <= state_d;
      grant <= grant_d;
      ptr <= ptr_d;
      owner <= owner_d;
      crc <= crc_d;
      err <= err_d;
    end
  end

  assign o_ch_grant = grant;
  assign o_crc_busy = state == ARB_LOCK;
  assign o_txrx_crc_value = crc;
  assign o_txrx_crc_valid = state == ARB_DONE;
  assign o_ch_err = err;
endmodule

// File: tb/tb_ddr_crc_arbiter.sv
// tb_ddr_crc_arbiter: table vectors, corner sequences and a random 3-channel 16-bit run, scoreboarded against a bit-serial CRC model
module tb_ddr_crc_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] en0, v0, l0, gnt0, err0;
  logic [15:0] d0;
  logic ab0, busy0, val0;
  logic [4:0] crc0;
  logic [2:0] en1, v1, l1, gnt1, err1;
  logic [47:0] d1;
  logic busy1, val1;
  logic [4:0] crc1;

  ddr_crc_arbiter u0 (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_ch_en(en0), .i_ch_data_valid(v0),
    .i_ch_last_byte(l0), .i_ch_data(d0), .i_ddrccc_abort(ab0), .o_ch_grant(gnt0),
    .o_crc_busy(busy0), .o_txrx_crc_value(crc0), .o_txrx_crc_valid(val0), .o_ch_err(err0)
  );

  ddr_crc_arbiter #(.N_CH(3), .DATA_W(16)) u1 (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_ch_en(en1), .i_ch_data_valid(v1),
    .i_ch_last_byte(l1), .i_ch_data(d1), .i_ddrccc_abort(1'b0), .o_ch_grant(gnt1),
    .o_crc_busy(busy1), .o_txrx_crc_value(crc1), .o_txrx_crc_valid(val1), .o_ch_err(err1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] q0[$];
  logic [4:0] q1[$];
  logic [4:0] g0, g1;

  typedef struct { int ch; logic [7:0] d; logic [4:0] exp; } vec_t;
  vec_t tbl[6];

  function automatic logic [4:0] m5(input logic [4:0] c, input logic [15:0] d, input int n);
    logic [4:0] r;
    logic fb;
    r = c;
    for (int i = n - 1; i >= 0; i--) begin
      fb = r[4] ^ d[i];
      r = {r[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && val0) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL crc0_pulse: got valid with crc %0h expected no pulse", crc0);
      end else check("crc0_final", 64'(crc0), 64'(q0.pop_front()));
    end
    if (rst && val1) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL crc1_pulse: got valid with crc %0h expected no pulse", crc1);
      end else check("crc1_final", 64'(crc1), 64'(q1.pop_front()));
    end
  end

  task automatic wait_grant0(input int ch);
    int k;
    k = 0;
    while (k < 10 && gnt0 !== (2'b01 << ch)) begin
      @(negedge clk);
      k++;
    end
    check("grant0", 64'(gnt0), 64'(2'b01 << ch));
    check("busy0", 64'(busy0), 64'd1);
  endtask

  task automatic wait_grant1(input int ch);
    int k;
    k = 0;
    while (k < 10 && gnt1 !== (3'b001 << ch)) begin
      @(negedge clk);
      k++;
    end
    check("grant1", 64'(gnt1), 64'(3'b001 << ch));
  endtask

  task automatic beat0(input int ch, input logic [7:0] d, input logic last, input logic [4:0] exp);
    v0 = '0;
    l0 = '0;
    v0[ch] = 1'b1;
    l0[ch] = last;
    d0[ch*8 +: 8] = d;
    if (last) q0.push_back(exp);
    @(negedge clk);
    v0 = '0;
    l0 = '0;
  endtask

  task automatic idle0(input string nm);
    check(nm, {gnt0, busy0, val0, crc0}, {2'b00, 1'b0, 1'b0, 5'h1F});
  endtask

  initial begin
    int ch, len;
    logic [15:0] d;
    logic [2:0] om;
    en0 = '0; v0 = '0; l0 = '0; d0 = '0; ab0 = 1'b0;
    en1 = '0; v1 = '0; l1 = '0; d1 = '0;
    repeat (3) @(negedge clk);
    idle0("in_reset");
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idle0("idle_after_reset");
    end
    // both request from reset: ch0 first, then ch1 by rotation even though ch0 keeps asking
    en0 = 2'b11;
    wait_grant0(0);
    beat0(0, 8'hA5, 1'b1, m5(5'h1F, 16'h00A5, 8));
    wait_grant0(1);
    en0[0] = 1'b0;
    beat0(1, 8'h3C, 1'b1, m5(5'h1F, 16'h003C, 8));
    en0 = '0;
    repeat (2) @(negedge clk);

    tbl[0] = '{0, 8'h00, 5'h0F};
    tbl[1] = '{1, 8'hFF, 5'h1B};
    for (int i = 2; i < 6; i++) begin
      tbl[i].ch = i % 2;
      tbl[i].d = 8'($urandom);
      tbl[i].exp = m5(5'h1F, 16'(tbl[i].d), 8);
    end
    for (int i = 0; i < 6; i++) begin
      en0[tbl[i].ch] = 1'b1;
      @(negedge clk);
      check("tbl_grant", 64'(gnt0), 64'(2'b01 << tbl[i].ch));
      beat0(tbl[i].ch, tbl[i].d, 1'b1, tbl[i].exp);
      en0 = '0;
      check("tbl_done_grant", {gnt0, busy0}, 3'b000);
      @(negedge clk);
      idle0("tbl_after_done");
      @(negedge clk);
    end

    // non-owner beat alongside the owner's last beat
    en0 = 2'b01;
    wait_grant0(0);
    v0 = 2'b11;
    l0 = 2'b01;
    d0 = 16'h5512;
    q0.push_back(m5(5'h1F, 16'h0012, 8));
    @(negedge clk);
    v0 = '0;
    l0 = '0;
    check("err_pulse", 64'(err0), 64'(2'b10));
    en0 = '0;
    @(negedge clk);
    check("err_clear", 64'(err0), 64'(2'b00));
    @(negedge clk);

    // abort mid-frame, with a last beat that it must override
    en0 = 2'b01;
    wait_grant0(0);
    beat0(0, 8'h11, 1'b0, 5'h00);
    beat0(0, 8'h22, 1'b0, 5'h00);
    check("mid_crc", 64'(crc0), 64'(m5(m5(5'h1F, 16'h0011, 8), 16'h0022, 8)));
    v0 = 2'b01; l0 = 2'b01; d0 = 16'h0033; ab0 = 1'b1;
    @(negedge clk);
    ab0 = 1'b0; v0 = '0; l0 = '0; en0 = '0;
    idle0("abort_idle");
    @(negedge clk);
    idle0("abort_stay");

    // owner drops its request during a valid last beat
    en0 = 2'b01;
    wait_grant0(0);
    beat0(0, 8'h44, 1'b0, 5'h00);
    beat0(0, 8'h55, 1'b0, 5'h00);
    v0 = 2'b01; l0 = 2'b01; d0 = 16'h0066; en0 = '0;
    @(negedge clk);
    v0 = '0; l0 = '0;
    idle0("drop_idle");
    @(negedge clk);
    idle0("drop_stay");

    // reset mid-frame
    en0 = 2'b10;
    wait_grant0(1);
    beat0(1, 8'h77, 1'b0, 5'h00);
    beat0(1, 8'h88, 1'b0, 5'h00);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    en0 = '0;
    idle0("reset_idle");
    @(negedge clk);
    idle0("reset_stay");

    for (int f = 0; f < 30; f++) begin
      ch = $urandom_range(0, 2);
      en1[ch] = 1'b1;
      wait_grant1(ch);
      g1 = 5'h1F;
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        d = 16'($urandom);
        g1 = m5(g1, d, 16);
        om = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) & ~(3'b001 << ch) : 3'b000;
        d1 = {16'($urandom), 16'($urandom), 16'($urandom)};
        d1[ch*16 +: 16] = d;
        v1 = (3'b001 << ch) | om;
        l1 = (b == len - 1) ? (3'b001 << ch) : 3'b000;
        if (b == len - 1) q1.push_back(g1);
        @(negedge clk);
        v1 = '0;
        l1 = '0;
        check("err1", 64'(err1), 64'(om));
        if (b < len - 1 && $urandom_range(0, 3) == 0) @(negedge clk);
      end
      en1 = '0;
      repeat (2) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
